pulse_generator: RTL and testbench
==================================

PULSE_GENERATOR -- requirements
Module: pulse_generator

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 16: width of the phase-length and pulse-count inputs.
REQ-002 SHALL have port CLK  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port RSTN  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port START  input  1  request to begin a pulse sequence; sampled only in IDLE.
REQ-005 SHALL have port ABORT  input  1  terminate any sequence in progress.
REQ-006 SHALL have port HIGH_CYCLES  input  CNT_WIDTH  high-phase length in cycles; latched on accepted START.
REQ-007 SHALL have port LOW_CYCLES  input  CNT_WIDTH  gap between pulses in cycles; latched on accepted START.
REQ-008 SHALL have port NUM_PULSES  input  CNT_WIDTH  pulse count, present only with PULSE_GENERATOR_REPEAT_EN; latched on accepted START.
REQ-009 SHALL have port PULSE_OUT  output  1  generated waveform, driven directly from a flop.
REQ-010 SHALL have port BUSY  output  1  sequence in progress.
REQ-011 SHALL have port DONE  output  1  single-cycle completion strobe.

Function
REQ-012 SHALL implement FSM states IDLE, HIGH, LOW, DONE.
REQ-013 IDLE: START=1 and ABORT=0 at edge t SHALL latch the inputs and enter HIGH, with PULSE_OUT=1 and BUSY=1 from t+1.
REQ-014 HIGH_CYCLES=0 or LOW_CYCLES=0 SHALL be treated as 1.
REQ-015 HIGH SHALL hold PULSE_OUT=1 for exactly H cycles, then go to LOW if pulses remain, else to DONE.
REQ-016 LOW SHALL hold PULSE_OUT=0 for exactly L cycles, then go to HIGH.
REQ-017 DONE SHALL last one cycle with DONE=1, BUSY=1, PULSE_OUT=0, then go to IDLE.
REQ-018 N-pulse sequence: DONE SHALL assert at cycle t + N*H + (N-1)*L + 1; no trailing low phase.
REQ-019 START while not in IDLE SHALL be ignored; a new START SHALL be accepted at earliest in the cycle after DONE.
REQ-020 Changes on HIGH_CYCLES, LOW_CYCLES or NUM_PULSES while BUSY SHALL have no effect on the running sequence.
REQ-021 ABORT=1 in any non-IDLE state SHALL force IDLE on the next edge: PULSE_OUT=0, BUSY=0, no DONE strobe.
REQ-022 ABORT and START together in IDLE SHALL leave the block in IDLE.
REQ-023 Phase counters SHALL be CNT_WIDTH-bit down-counters, with no wrap-around at any legal input value including all-ones.

Reset
REQ-024 RSTN=0 at a rising edge SHALL force IDLE, PULSE_OUT=0, BUSY=0, DONE=0, and clear counters and latched configuration.
REQ-025 Reset mid-sequence SHALL abandon the sequence without a DONE strobe.

Configuration
REQ-026 With PULSE_GENERATOR_REPEAT_EN defined, NUM_PULSES SHALL exist; NUM_PULSES=0 means endless (HIGH/LOW repeat until ABORT, DONE never asserts); N>0 yields exactly N pulses.
REQ-027 Without PULSE_GENERATOR_REPEAT_EN, NUM_PULSES SHALL be absent, N SHALL be fixed at 1, and the LOW state SHALL be unreachable.

Structure
REQ-028 Package pulse_generator_pkg SHALL hold the FSM state typedef and the default CNT_WIDTH constant.
REQ-029 The phase down-counter SHALL be the sub-module pulse_gen_counter (load, decrement, zero flag), used for the phase counter and the pulse counter.

Verification
REQ-030 Single pulse: H=3, START at t -> PULSE_OUT high t+1..t+3; DONE only at t+4; BUSY high t+1..t+4.
REQ-031 Zero lengths: H=0 -> one-cycle pulse; with REPEAT_EN, L=0, N=2 -> high, low, high (1 cycle each), then DONE.
REQ-032 Repeat: H=2, L=3, N=3 -> PULSE_OUT pattern 1100011000110, DONE at t+13.
REQ-033 Endless: N=0, H=1, L=1 -> square wave for 100 cycles with DONE=0; ABORT -> PULSE_OUT=0, BUSY=0 on the next cycle.
REQ-034 Ignored inputs: START pulses and HIGH_CYCLES changes mid-sequence -> waveform unchanged; ABORT with START in IDLE -> stays IDLE.
REQ-035 Reset: RSTN=0 during HIGH with H=10 -> all outputs 0 on the next cycle, no DONE strobe.

Source files
------------

// File: rtl/pulse_generator_pkg.sv
// rtl/pulse_generator_pkg.sv - shared state encoding and default width for pulse_generator
package pulse_generator_pkg;

    localparam int PG_CNT_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2,
        ST_DONE = 2'd3
    } pg_state_e;

endpackage

// File: rtl/pulse_gen_counter.sv
// rtl/pulse_gen_counter.sv - loadable down-counter with zero flag, saturating at zero
module pulse_gen_counter #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pulse_generator.sv
// rtl/pulse_generator.sv - programmable pulse train generator; PULSE_GENERATOR_REPEAT_EN adds NUM_PULSES
module pulse_generator
    import pulse_generator_pkg::*;
#(
    parameter int CNT_WIDTH = PG_CNT_WIDTH
) (
    input  logic                 CLK,
    input  logic                 RSTN,
    input  logic                 START,
    input  logic                 ABORT,
    input  logic [CNT_WIDTH-1:0] HIGH_CYCLES,
    input  logic [CNT_WIDTH-1:0] LOW_CYCLES,
`ifdef PULSE_GENERATOR_REPEAT_EN
    input  logic [CNT_WIDTH-1:0] NUM_PULSES,
`endif
    output logic                 PULSE_OUT,
    output logic                 BUSY,
    output logic                 DONE
);

    // Counters hold "cycles remaining minus one", so a zero length folds onto one cycle.
    function automatic logic [CNT_WIDTH-1:0] len_m1(input logic [CNT_WIDTH-1:0] v);
        return (v == '0) ? '0 : v - 1'b1;
    endfunction

    pg_state_e              state_q;
    logic                   pulse_q;
    logic                   busy_q;
    logic                   done_q;

    logic                   accept;
    logic                   more_pulses;
    logic                   phase_load;
    logic [CNT_WIDTH-1:0]   phase_val;
    logic                   phase_dec;
    logic                   phase_zero;

`ifdef PULSE_GENERATOR_REPEAT_EN
    logic [CNT_WIDTH-1:0]   h_m1_q;
    logic [CNT_WIDTH-1:0]   l_m1_q;
    logic                   endless_q;
    logic                   pls_dec;
    logic                   pls_zero;

    pulse_gen_counter #(.WIDTH(CNT_WIDTH)) u_pulse_cnt (
        .CLK        (CLK),
        .RSTN       (RSTN),
        .load_i     (accept),
        .load_val_i (len_m1(NUM_PULSES)),
        .dec_i      (pls_dec),
        .zero_o     (pls_zero)
    );

    assign more_pulses = endless_q || !pls_zero;
`else
    logic unused_low;
    assign unused_low  = ^LOW_CYCLES;
    assign more_pulses = 1'b0;
`endif

    pulse_gen_counter #(.WIDTH(CNT_WIDTH)) u_phase_cnt (
        .CLK        (CLK),
        .RSTN       (RSTN),
        .load_i     (phase_load),
        .load_val_i (phase_val),
        .dec_i      (phase_dec),
        .zero_o     (phase_zero)
    );

    assign accept = (state_q == ST_IDLE) && START && !ABORT;

    always_comb begin
        phase_load = 1'b0;
        phase_val  = len_m1(HIGH_CYCLES);
        phase_dec  = 1'b0;
`ifdef PULSE_GENERATOR_REPEAT_EN
        pls_dec    = 1'b0;
`endif
        case (state_q)
            ST_IDLE: phase_load = accept;
            ST_HIGH: begin
                if (!ABORT) begin
                    if (!phase_zero) begin
                        phase_dec = 1'b1;
`ifdef PULSE_GENERATOR_REPEAT_EN
                    end else if (more_pulses) begin
                        phase_load = 1'b1;
                        phase_val  = l_m1_q;
                        pls_dec    = !pls_zero;
`endif
                    end
                end
            end
`ifdef PULSE_GENERATOR_REPEAT_EN
            ST_LOW: begin
                if (!ABORT) begin
                    if (phase_zero) begin
                        phase_load = 1'b1;
                        phase_val  = h_m1_q;
                    end else begin
                        phase_dec = 1'b1;
                    end
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q   <= ST_IDLE;
            pulse_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef PULSE_GENERATOR_REPEAT_EN
            h_m1_q    <= '0;
            l_m1_q    <= '0;
            endless_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            if ((state_q != ST_IDLE) && ABORT) begin
                state_q <= ST_IDLE;
                pulse_q <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (accept) begin
                            state_q   <= ST_HIGH;
                            pulse_q   <= 1'b1;
                            busy_q    <= 1'b1;
`ifdef PULSE_GENERATOR_REPEAT_EN
                            h_m1_q    <= len_m1(HIGH_CYCLES);
                            l_m1_q    <= len_m1(LOW_CYCLES);
                            endless_q <= (NUM_PULSES == '0);
`endif
                        end
                    end
                    ST_HIGH: begin
                        if (phase_zero) begin
                            pulse_q <= 1'b0;
                            if (more_pulses) begin
                                state_q <= ST_LOW;
                            end else begin
                                state_q <= ST_DONE;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                    ST_LOW: begin
                        if (phase_zero) begin
                            state_q <= ST_HIGH;
                            pulse_q <= 1'b1;
                        end
                    end
                    ST_DONE: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign PULSE_OUT = pulse_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;

endmodule

// File: tb/tb_pulse_generator.sv
// tb/tb_pulse_generator.sv - directed, table-driven bench for pulse_generator
module tb_pulse_generator;

    localparam int CNT_WIDTH = 16;

    typedef struct {
        string                name;
        logic [CNT_WIDTH-1:0] h;
        logic [CNT_WIDTH-1:0] l;
        logic [CNT_WIDTH-1:0] n;
        bit                   noise;
        logic [31:0]          pat;
        int                   len;
    } vec_t;

    logic                 clk;
    logic                 rstn;
    logic                 start;
    logic                 abort;
    logic [CNT_WIDTH-1:0] high_cycles;
    logic [CNT_WIDTH-1:0] low_cycles;
`ifdef PULSE_GENERATOR_REPEAT_EN
    logic [CNT_WIDTH-1:0] num_pulses;
`endif
    logic                 pulse_out;
    logic                 busy;
    logic                 done;

    int checks   = 0;
    int failures = 0;

    pulse_generator #(.CNT_WIDTH(CNT_WIDTH)) dut (
        .CLK         (clk),
        .RSTN        (rstn),
        .START       (start),
        .ABORT       (abort),
        .HIGH_CYCLES (high_cycles),
        .LOW_CYCLES  (low_cycles),
`ifdef PULSE_GENERATOR_REPEAT_EN
        .NUM_PULSES  (num_pulses),
`endif
        .PULSE_OUT   (pulse_out),
        .BUSY        (busy),
        .DONE        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endfunction

    function automatic vec_t mk(input string nm, input int h, input int l, input int n,
                                input bit noise, input logic [31:0] pat, input int len);
        vec_t v;
        v.name  = nm;
        v.h     = h[CNT_WIDTH-1:0];
        v.l     = l[CNT_WIDTH-1:0];
        v.n     = n[CNT_WIDTH-1:0];
        v.noise = noise;
        v.pat   = pat;
        v.len   = len;
        return v;
    endfunction

    task automatic check_idle(input string nm);
        check({nm, "_pulse"}, {31'd0, pulse_out}, 32'd0);
        check({nm, "_busy"},  {31'd0, busy},      32'd0);
        check({nm, "_done"},  {31'd0, done},      32'd0);
    endtask

    // Pattern covers cycles t+1 .. DONE cycle, MSB first; DONE expected on the last one.
    task automatic run_vec(input vec_t v);
        @(negedge clk);
        high_cycles = v.h;
        low_cycles  = v.l;
`ifdef PULSE_GENERATOR_REPEAT_EN
        num_pulses  = v.n;
`endif
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < v.len; k++) begin
            check($sformatf("%s_pulse[%0d]", v.name, k), {31'd0, pulse_out}, {31'd0, v.pat[v.len-1-k]});
            check($sformatf("%s_busy[%0d]", v.name, k),  {31'd0, busy}, 32'd1);
            check($sformatf("%s_done[%0d]", v.name, k),  {31'd0, done}, {31'd0, (k == v.len-1)});
            if (v.noise && (k < v.len-1)) begin
                start       = ~start;
                high_cycles = CNT_WIDTH'($urandom_range(0, 40));
                low_cycles  = CNT_WIDTH'($urandom_range(0, 40));
`ifdef PULSE_GENERATOR_REPEAT_EN
                num_pulses  = CNT_WIDTH'($urandom_range(0, 9));
`endif
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        check_idle({v.name, "_after"});
    endtask

    vec_t vecs[$];

    initial begin
        rstn        = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        high_cycles = '0;
        low_cycles  = '0;
`ifdef PULSE_GENERATOR_REPEAT_EN
        num_pulses  = '0;
`endif

        vecs.push_back(mk("single_h3", 3, 0, 1, 1'b0, 32'b1110, 4));
        vecs.push_back(mk("zero_h",    0, 0, 1, 1'b0, 32'b10, 2));
        vecs.push_back(mk("h1_l7",     1, 7, 1, 1'b0, 32'b10, 2));
        vecs.push_back(mk("h5_noise",  5, 2, 1, 1'b1, 32'b111110, 6));
`ifdef PULSE_GENERATOR_REPEAT_EN
        vecs.push_back(mk("rep_2_3_3", 2, 3, 3, 1'b0, 32'b1100011000110, 13));
        vecs.push_back(mk("zero_l_n2", 0, 0, 2, 1'b0, 32'b1010, 4));
        vecs.push_back(mk("rep_noise", 1, 2, 2, 1'b1, 32'b10010, 5));
        vecs.push_back(mk("n1_l5",     2, 5, 1, 1'b0, 32'b110, 3));
`endif

        repeat (3) @(negedge clk);
        check_idle("reset");
        rstn = 1'b1;
        @(negedge clk);
        check_idle("post_reset");

        foreach (vecs[i]) run_vec(vecs[i]);

        // START held high: restart is accepted only in the idle cycle after DONE
        high_cycles = 16'd1;
`ifdef PULSE_GENERATOR_REPEAT_EN
        num_pulses  = 16'd1;
`endif
        start = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            check($sformatf("held_start_pulse[%0d]", k), {31'd0, pulse_out}, {31'd0, (k % 3 == 0)});
            check($sformatf("held_start_busy[%0d]", k),  {31'd0, busy},      {31'd0, (k % 3 != 2)});
            check($sformatf("held_start_done[%0d]", k),  {31'd0, done},      {31'd0, (k % 3 == 1)});
            @(negedge clk);
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("held_start_end");

        // ABORT together with START in IDLE
        abort = 1'b1;
        start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_idle($sformatf("abort_start_idle[%0d]", k));
        end
        abort = 1'b0;
        start = 1'b0;

        // ABORT during a long high phase
        high_cycles = 16'd10;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_mid_pulse", {31'd0, pulse_out}, 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_idle("abort_next");
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check($sformatf("abort_no_done[%0d]", k), {30'd0, busy, done}, 32'd0);
        end

        // Reset during a long high phase
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_mid_pulse", {31'd0, pulse_out}, 32'd1);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        check_idle("reset_next");
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check($sformatf("reset_no_done[%0d]", k), {30'd0, busy, done}, 32'd0);
        end

        // All-ones high length must not wrap to a short pulse
        high_cycles = '1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 40; k++) begin
            check($sformatf("allones_high[%0d]", k), {29'd0, pulse_out, busy, done}, 32'b110);
            @(negedge clk);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_idle("allones_abort");

`ifdef PULSE_GENERATOR_REPEAT_EN
        // Endless square wave until ABORT
        high_cycles = 16'd1;
        low_cycles  = 16'd1;
        num_pulses  = 16'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 100; k++) begin
            check($sformatf("endless[%0d]", k), {29'd0, pulse_out, busy, done},
                  {29'd0, (k % 2 == 0), 1'b1, 1'b0});
            @(negedge clk);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_idle("endless_abort");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
